// File: rtl/led_pwm_array.sv
// led_pwm_array: register-programmed LED driver array.
// Each channel is off, on, PWM-dimmed, or PWM-dimmed and gated by a slow group blink.
// A shared PWM counter drives every channel. Each channel compares the counter against
// a shadowed duty value, which only reloads at a period boundary.
module led_pwm_array #(
  parameter int NUM_CH    = 8,
  parameter int PWM_BITS  = 8,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  input  logic                 w_en,
  input  logic                 r_en,
  output logic [7:0]           rdata,
  output logic                 rvalid,
  output logic [NUM_CH-1:0]    leds,
  output logic                 sleep,
  output logic                 period_start
);

  localparam int NUM_LO  = (NUM_CH + 3) / 4;
  localparam int LO_BASE = 3 + NUM_CH;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("led_pwm_array: NUM_CH must be 1..16");
  end
  if ((PWM_BITS < 4) || (PWM_BITS > 8)) begin : g_bad_pwm_bits
    $error("led_pwm_array: PWM_BITS must be 4..8");
  end
  if ((LO_BASE + NUM_LO) > (2 ** ADDR_BITS)) begin : g_bad_addr_bits
    $error("led_pwm_array: register map does not fit in ADDR_BITS");
  end

  logic                mode_sleep;
  logic                mode_invrt;
  logic [7:0]          grpduty;
  logic [7:0]          grpfreq;
  logic [7:0]          pwm_reg  [NUM_CH];
  logic [1:0]          led_mode [NUM_CH];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow   [NUM_CH];
  logic [7:0]          blink_cnt;
  logic [7:0]          rd_mux;
  logic [NUM_CH-1:0]   led_val;
  logic                wr_mode;
  logic                sleep_nxt;
  logic                cnt_wrap;
  logic                group_on;

  // Sleep is looked at one write early, so the counter is already 0 in the
  // first sleeping cycle and never shows a stray count.
  assign wr_mode      = w_en && (addr == ADDR_BITS'(0));
  assign sleep_nxt    = wr_mode ? wdata[4] : mode_sleep;
  assign cnt_wrap     = !mode_sleep && (pwm_cnt == CNT_MAX);
  assign group_on     = (blink_cnt < grpduty);
  assign sleep        = mode_sleep;
  assign period_start = !mode_sleep && (pwm_cnt == '0);

  // Register file writes; LEDOUT bits of channels that do not exist are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_sleep <= 1'b1;
      mode_invrt <= 1'b0;
      grpduty    <= 8'hFF;
      grpfreq    <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_reg[i]  <= '0;
        led_mode[i] <= '0;
      end
    end else if (w_en) begin
      if (addr == ADDR_BITS'(0)) begin
        mode_sleep <= wdata[4];
        mode_invrt <= wdata[2];
      end
      if (addr == ADDR_BITS'(1)) grpduty <= wdata;
      if (addr == ADDR_BITS'(2)) grpfreq <= wdata;
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_BITS'(3 + i)) pwm_reg[i] <= wdata;
        if (addr == ADDR_BITS'(LO_BASE + i / 4)) led_mode[i] <= wdata[2*(i%4) +: 2];
      end
    end
  end

  // Read decode from the current register state; a write in the same cycle is not yet visible.
  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_BITS'(0)) rd_mux = {3'b000, mode_sleep, 1'b0, mode_invrt, 2'b00};
    if (addr == ADDR_BITS'(1)) rd_mux = grpduty;
    if (addr == ADDR_BITS'(2)) rd_mux = grpfreq;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_BITS'(3 + i)) rd_mux = pwm_reg[i];
      if (addr == ADDR_BITS'(LO_BASE + i / 4)) rd_mux[2*(i%4) +: 2] = led_mode[i];
    end
  end

  // Read response: rvalid pulses one cycle after r_en, and rdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= 8'h00;
      rvalid <= 1'b0;
    end else begin
      rvalid <= r_en;
      if (r_en) rdata <= rd_mux;
    end
  end

  // PWM counter: free-running while awake; parked at 0 while asleep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (mode_sleep || sleep_nxt) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Blink counter: one step per PWM period. The >= compare recovers when GRPFREQ drops below the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= 8'h00;
    end else if (cnt_wrap) begin
      blink_cnt <= (blink_cnt >= grpfreq) ? 8'h00 : blink_cnt + 8'd1;
    end
  end

  // Duty shadows: reload only at period end, or continuously while asleep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (mode_sleep || cnt_wrap) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= pwm_reg[i][7 -: PWM_BITS];
    end
  end

  // Per-channel mode select, before inversion.
  always_comb begin
    led_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (led_mode[i])
        2'b00:   led_val[i] = 1'b0;
        2'b01:   led_val[i] = 1'b1;
        2'b10:   led_val[i] = (pwm_cnt < shadow[i]);
        default: led_val[i] = (pwm_cnt < shadow[i]) && group_on;
      endcase
    end
  end

  // Output register: while asleep every LED sits at the inactive level set by INVRT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= '0;
    end else if (mode_sleep) begin
      leds <= {NUM_CH{mode_invrt}};
    end else begin
      leds <= led_val ^ {NUM_CH{mode_invrt}};
    end
  end

endmodule

// File: tb/tb_led_pwm_array.sv
// tb_led_pwm_array: register vectors from a table, plus PWM, blink and sleep sequences.
// The DUT is built with 6 channels, so LEDOUT1 has unused upper bits.
module tb_led_pwm_array;

  localparam int NCH = 6;

  logic           clk;
  logic           reset;
  logic [4:0]     addr;
  logic [7:0]     wdata;
  logic           w_en;
  logic           r_en;
  logic [7:0]     rdata;
  logic           rvalid;
  logic [NCH-1:0] leds;
  logic           sleep;
  logic           period_start;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_rd;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  led_pwm_array #(.NUM_CH(NCH), .PWM_BITS(8), .ADDR_BITS(5)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .w_en(w_en), .r_en(r_en),
    .rdata(rdata), .rvalid(rvalid), .leds(leds), .sleep(sleep), .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    addr = a; wdata = d; w_en = 1'b1;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string nm);
    addr = a; r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk({nm, "_rvalid"}, rvalid, 1);
    chk(nm, rdata, exp);
  endtask

  task automatic reset_dut();
    reset = 1'b1; w_en = 1'b0; r_en = 1'b0; addr = '0; wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    last_rd = 8'h00;
  endtask

  task automatic wait_ps(input int budget, input string nm);
    int n;
    n = 0;
    while (!period_start && n < budget) begin
      tick();
      n++;
    end
    chk(nm, period_start, 1);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int h [8];
    int exp_h [8];

    vecs[0]  = '{1'b0, 1'b1, 5'h00, 8'h00, 8'h10};
    vecs[1]  = '{1'b0, 1'b1, 5'h01, 8'h00, 8'hFF};
    vecs[2]  = '{1'b0, 1'b1, 5'h02, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 5'h03, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 5'h03, 8'hA5, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 5'h03, 8'h00, 8'hA5};
    vecs[6]  = '{1'b1, 1'b0, 5'h08, 8'h3C, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 5'h08, 8'h00, 8'h3C};
    vecs[8]  = '{1'b1, 1'b0, 5'h09, 8'hE4, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 5'h09, 8'h00, 8'hE4};
    vecs[10] = '{1'b1, 1'b0, 5'h0A, 8'hFF, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 5'h0A, 8'h00, 8'h0F};
    vecs[12] = '{1'b0, 1'b1, 5'h0B, 8'h00, 8'h00};
    vecs[13] = '{1'b1, 1'b0, 5'h0B, 8'h55, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 5'h0B, 8'h00, 8'h00};
    vecs[15] = '{1'b0, 1'b1, 5'h1F, 8'h00, 8'h00};
    vecs[16] = '{1'b1, 1'b0, 5'h01, 8'h5A, 8'h00};
    vecs[17] = '{1'b0, 1'b1, 5'h01, 8'h00, 8'h5A};
    vecs[18] = '{1'b1, 1'b0, 5'h02, 8'hC3, 8'h00};
    vecs[19] = '{1'b0, 1'b1, 5'h02, 8'h00, 8'hC3};
    vecs[20] = '{1'b1, 1'b0, 5'h00, 8'hFF, 8'h00};
    vecs[21] = '{1'b0, 1'b1, 5'h00, 8'h00, 8'h14};
    vecs[22] = '{1'b1, 1'b0, 5'h00, 8'h10, 8'h00};
    vecs[23] = '{1'b1, 1'b1, 5'h00, 8'h07, 8'h10};
    vecs[24] = '{1'b0, 1'b1, 5'h00, 8'h00, 8'h04};
    vecs[25] = '{1'b1, 1'b0, 5'h00, 8'h10, 8'h00};
    vecs[26] = '{1'b0, 1'b1, 5'h00, 8'h00, 8'h10};
    vecs[27] = '{1'b0, 1'b1, 5'h05, 8'h00, 8'h00};

    // Power-up reset state.
    reset_dut();
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_leds", leds, 0);
    chk("rst_sleep", sleep, 1);
    chk("rst_period_start", period_start, 0);

    // While asleep, no period_start pulse and the LEDs stay dark.
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      cnt_a += int'(period_start);
      cnt_b += int'(leds != '0);
    end
    chk("sleep_no_period_start", cnt_a, 0);
    chk("sleep_leds_dark", cnt_b, 0);

    // Register map vectors.
    for (int i = 0; i < NV; i++) begin
      addr = vecs[i].a; wdata = vecs[i].d; w_en = vecs[i].wr; r_en = vecs[i].rd;
      tick();
      w_en = 1'b0; r_en = 1'b0;
      chk($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].rd);
      if (vecs[i].rd) last_rd = vecs[i].exp;
      chk($sformatf("vec%0d_rdata", i), rdata, last_rd);
    end
    tick();
    chk("idle_rvalid", rvalid, 0);
    chk("idle_rdata_hold", rdata, last_rd);

    // A read is pending when reset asserts; it must never return.
    addr = 5'h00; r_en = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk("rst_midread_rdata", rdata, 8'h00);
    tick();
    chk("rst_midread_rvalid", rvalid, 0);
    r_en = 1'b0;
    reset = 1'b0;

    // Duty 0x40 on ch0 in PWM mode, with ch1 forced on.
    reset_dut();
    wr(5'h03, 8'h40);
    wr(5'h09, 8'h06);
    wr(5'h00, 8'h00);
    wait_ps(300, "b_wait_period_start");
    chk("b_first_cycle_led0", leds[0], 0);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (k == 0) chk("b_rise_after_ps", leds[0], 1);
      cnt_a += int'(leds[0]);
      cnt_b += int'(period_start);
    end
    chk("b_high_cycles", cnt_a, 64);
    chk("b_ps_per_period", cnt_b, 1);
    chk("b_ch1_on", leds[1], 1);

    // Changing the duty mid-period does not disturb the current period.
    wait_ps(300, "c_wait_period_start");
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 512; k++) begin
      if (k == 16) begin addr = 5'h03; wdata = 8'h80; w_en = 1'b1; end
      tick();
      w_en = 1'b0;
      if (k < 256) cnt_a += int'(leds[0]);
      else         cnt_b += int'(leds[0]);
    end
    chk("c_period_old_duty", cnt_a, 64);
    chk("c_period_new_duty", cnt_b, 128);

    // Reset in the middle of a period, then registers return to power-up values.
    repeat (5) tick();
    chk("d_led0_before_rst", leds[0], 1);
    reset = 1'b1;
    #1;
    chk("d_rst_leds", leds, 0);
    chk("d_rst_sleep", sleep, 1);
    chk("d_rst_period_start", period_start, 0);
    tick();
    reset = 1'b0;
    rd(5'h03, 8'h00, "d_pwm0_after_rst");
    rd(5'h09, 8'h00, "d_ledout0_after_rst");

    // Group blink: period of 4 PWM periods, on for the first 2.
    reset_dut();
    wr(5'h02, 8'h03);
    wr(5'h01, 8'h02);
    wr(5'h04, 8'hFF);
    wr(5'h09, 8'h0C);
    wr(5'h00, 8'h00);
    wait_ps(300, "e_wait_period_start");
    for (int p = 0; p < 8; p++) h[p] = 0;
    for (int k = 0; k < 2048; k++) begin
      tick();
      h[k/256] += int'(leds[1]);
    end
    exp_h = '{255, 255, 0, 0, 255, 255, 0, 0};
    for (int p = 0; p < 8; p++) chk($sformatf("e_blink_period%0d", p), h[p], exp_h[p]);

    // Inverted outputs, then sleep entered mid-period and cleared again.
    reset_dut();
    wr(5'h00, 8'h04);
    tick();
    chk("f_invrt_leds", leds, 6'h3F);
    repeat (40) tick();
    wr(5'h00, 8'h14);
    cnt_a = 0;
    for (int k = 0; k < 20; k++) begin
      if ((leds != 6'h3F) || period_start) cnt_a++;
      tick();
    end
    chk("f_sleep_hold", cnt_a, 0);
    chk("f_sleep_out", sleep, 1);
    wr(5'h00, 8'h04);
    chk("f_wake_period_start", period_start, 1);
    chk("f_wake_leds", leds, 6'h3F);
    tick();
    chk("f_wake_ps_one_cycle", period_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
